alarm_interval_timer: RTL and testbench

Seconds-based interval timer for the anti-theft controller. It sits directly downstream of the 1 Hz divider and consumes its one-cycle `one_hz_enable` pulse. It holds a small user-programmable table of four delay intervals (arm delay, driver-door delay, passenger-door delay, alarm-on time). On request from the alarm FSM it counts the selected interval down in whole seconds and then pulses `expired`.

---
 rtl/antitheft_pkg.sv | 24 ++
 rtl/interval_param_regs.sv | 46 ++++
 rtl/alarm_interval_timer.sv | 97 +++++++++
 tb/tb_alarm_interval_timer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antitheft_pkg.sv
// Shared definitions for the anti-theft controller.
// Holds the interval table index constants, the reset defaults for each
// interval (in seconds) and the state encoding of the interval timer FSM.
package antitheft_pkg;

  // Index of each entry in the interval table
  localparam logic [1:0] T_ARM_DELAY       = 2'd0;
  localparam logic [1:0] T_DRIVER_DELAY    = 2'd1;
  localparam logic [1:0] T_PASSENGER_DELAY = 2'd2;
  localparam logic [1:0] T_ALARM_ON        = 2'd3;

  // Reset contents of the interval table, in seconds
  localparam logic [3:0] DEFAULT_ARM_DELAY       = 4'd6;
  localparam logic [3:0] DEFAULT_DRIVER_DELAY    = 4'd8;
  localparam logic [3:0] DEFAULT_PASSENGER_DELAY = 4'd15;
  localparam logic [3:0] DEFAULT_ALARM_ON        = 4'd10;

  // Interval timer FSM states
  typedef enum logic {
    TIMER_IDLE = 1'b0,
    TIMER_RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/interval_param_regs.sv
// Interval table: four 4-bit user-programmable delay entries.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   wr_en           one-cycle write strobe
//   wr_sel          entry to write
//   wr_value        value to write in seconds (0 is stored as 1)
//   rd_sel          entry to read
//   rd_value        combinational read of entry rd_sel (pre-write contents)
module interval_param_regs
  import antitheft_pkg::*;
#(
  parameter logic [3:0] DEF_ARM_DELAY       = DEFAULT_ARM_DELAY,
  parameter logic [3:0] DEF_DRIVER_DELAY    = DEFAULT_DRIVER_DELAY,
  parameter logic [3:0] DEF_PASSENGER_DELAY = DEFAULT_PASSENGER_DELAY,
  parameter logic [3:0] DEF_ALARM_ON        = DEFAULT_ALARM_ON
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [3:0] wr_value,
  input  logic [1:0] rd_sel,
  output logic [3:0] rd_value
);

  logic [3:0] table_q [4];

  // Table storage. A programmed 0 is clamped to 1 so that a started
  // interval always lasts at least one tick and the counter never
  // starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_q[T_ARM_DELAY]       <= DEF_ARM_DELAY;
      table_q[T_DRIVER_DELAY]    <= DEF_DRIVER_DELAY;
      table_q[T_PASSENGER_DELAY] <= DEF_PASSENGER_DELAY;
      table_q[T_ALARM_ON]        <= DEF_ALARM_ON;
    end else if (wr_en) begin
      table_q[wr_sel] <= (wr_value == 4'd0) ? 4'd1 : wr_value;
    end
  end

  // Read port sees the registered contents, so a start coinciding with
  // a write to the same entry picks up the old value.
  assign rd_value = table_q[rd_sel];

endmodule

// File: rtl/alarm_interval_timer.sv
// Seconds-based interval timer for the anti-theft controller.
// Counts the selected table interval down on each 1 Hz enable and pulses
// expired for one cycle when it elapses.
// Ports:
//   clk, rst        100 MHz clock and asynchronous active-high reset
//   one_hz_enable   one-cycle tick, once per second
//   prog_sync       one-cycle write strobe for the interval table
//   time_param_sel  table entry to write
//   time_value      value to write, in seconds
//   interval        table entry to time on start
//   start_timer     one-cycle start/restart request
//   expired         one-cycle pulse when the interval elapses
//   busy            high while counting
//   remaining       seconds left; 0 when idle
module alarm_interval_timer
  import antitheft_pkg::*;
#(
  parameter logic [3:0] DEF_ARM_DELAY       = DEFAULT_ARM_DELAY,
  parameter logic [3:0] DEF_DRIVER_DELAY    = DEFAULT_DRIVER_DELAY,
  parameter logic [3:0] DEF_PASSENGER_DELAY = DEFAULT_PASSENGER_DELAY,
  parameter logic [3:0] DEF_ALARM_ON        = DEFAULT_ALARM_ON
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_hz_enable,
  input  logic       prog_sync,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic [1:0] interval,
  input  logic       start_timer,
  output logic       expired,
  output logic       busy,
  output logic [3:0] remaining
);

  timer_state_t state;
  logic [3:0]   interval_value;

  interval_param_regs #(
    .DEF_ARM_DELAY       (DEF_ARM_DELAY),
    .DEF_DRIVER_DELAY    (DEF_DRIVER_DELAY),
    .DEF_PASSENGER_DELAY (DEF_PASSENGER_DELAY),
    .DEF_ALARM_ON        (DEF_ALARM_ON)
  ) u_params (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (prog_sync),
    .wr_sel   (time_param_sel),
    .wr_value (time_value),
    .rd_sel   (interval),
    .rd_value (interval_value)
  );

  // Timer FSM and down-counter with registered outputs. A start always
  // takes priority over a tick, both from IDLE and as a restart in RUN,
  // so a coincident tick is simply not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TIMER_IDLE;
      remaining <= 4'd0;
      busy      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      case (state)
        TIMER_IDLE: begin
          if (start_timer) begin
            remaining <= interval_value;
            busy      <= 1'b1;
            state     <= TIMER_RUN;
          end
        end
        TIMER_RUN: begin
          if (start_timer) begin
            remaining <= interval_value;
          end else if (one_hz_enable) begin
            // The <= guard keeps the counter from ever wrapping below 0
            if (remaining <= 4'd1) begin
              remaining <= 4'd0;
              expired   <= 1'b1;
              busy      <= 1'b0;
              state     <= TIMER_IDLE;
            end else begin
              remaining <= remaining - 4'd1;
            end
          end
        end
        default: begin
          state     <= TIMER_IDLE;
          remaining <= 4'd0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_interval_timer.sv
// Directed self-checking testbench for alarm_interval_timer.
module tb_alarm_interval_timer;

  logic       clk;
  logic       rst;
  logic       one_hz_enable;
  logic       prog_sync;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic [1:0] interval;
  logic       start_timer;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  int checks = 0;
  int errors = 0;
  int exp_seen = 0;

  alarm_interval_timer dut (
    .clk            (clk),
    .rst            (rst),
    .one_hz_enable  (one_hz_enable),
    .prog_sync      (prog_sync),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .interval       (interval),
    .start_timer    (start_timer),
    .expired        (expired),
    .busy           (busy),
    .remaining      (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which expired is high, sampled away from the edge
  always @(negedge clk) if (expired) exp_seen++;

  // Advance one clock edge and settle just after it
  task step();
    @(posedge clk);
    #1;
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task pulse_tick();
    one_hz_enable = 1'b1;
    step();
    one_hz_enable = 1'b0;
  endtask

  task do_start(input logic [1:0] sel);
    interval    = sel;
    start_timer = 1'b1;
    step();
    start_timer = 1'b0;
  endtask

  task do_prog(input logic [1:0] sel, input logic [3:0] val);
    time_param_sel = sel;
    time_value     = val;
    prog_sync      = 1'b1;
    step();
    prog_sync      = 1'b0;
  endtask

  task test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({expired, busy, remaining} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got exp=%b busy=%b rem=%0d req 0/0/0", expired, busy, remaining);
    end
    #2 rst = 1'b0;
    idle(2);
    checks++;
    if ({expired, busy, remaining} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle got exp=%b busy=%b rem=%0d req 0/0/0", expired, busy, remaining);
    end
  endtask

  task test_defaults();
    do_start(2'd1);
    checks++;
    if ({expired, busy, remaining} !== {1'b0, 1'b1, 4'd8}) begin
      errors++;
      $display("[TB] FAIL default_start got exp=%b busy=%b rem=%0d req 0/1/8", expired, busy, remaining);
    end
    for (int i = 1; i <= 7; i++) begin
      idle(3);
      pulse_tick();
      checks++;
      if ({expired, busy, remaining} !== {1'b0, 1'b1, 4'(8 - i)}) begin
        errors++;
        $display("[TB] FAIL default_count tick %0d got exp=%b busy=%b rem=%0d req 0/1/%0d", i, expired, busy, remaining, 8 - i);
      end
    end
    idle(3);
    pulse_tick();
    checks++;
    if ({expired, busy, remaining} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL default_expire got exp=%b busy=%b rem=%0d req 1/0/0", expired, busy, remaining);
    end
    step();
    checks++;
    if ({expired, busy, remaining} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL expire_one_cycle got exp=%b busy=%b rem=%0d req 0/0/0", expired, busy, remaining);
    end
  endtask

  task test_program();
    do_prog(2'd3, 4'd3);
    do_start(2'd3);
    checks++;
    if (remaining !== 4'd3) begin
      errors++;
      $display("[TB] FAIL prog_start got rem=%0d req 3", remaining);
    end
    pulse_tick();
    idle(2);
    pulse_tick();
    checks++;
    if ({expired, busy, remaining} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL prog_two_ticks got exp=%b busy=%b rem=%0d req 0/1/1", expired, busy, remaining);
    end
    idle(2);
    pulse_tick();
    checks++;
    if ({expired, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL prog_expire got exp=%b busy=%b req 1/0", expired, busy);
    end
    do_prog(2'd0, 4'd0);
    do_start(2'd0);
    checks++;
    if ({busy, remaining} !== {1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL zero_clamp got busy=%b rem=%0d req 1/1", busy, remaining);
    end
    idle(2);
    pulse_tick();
    checks++;
    if ({expired, busy, remaining} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL zero_clamp_expire got exp=%b busy=%b rem=%0d req 1/0/0", expired, busy, remaining);
    end
    step();
  endtask

  task test_restart();
    int base;
    do_prog(2'd0, 4'd6);
    do_start(2'd2);
    checks++;
    if (remaining !== 4'd15) begin
      errors++;
      $display("[TB] FAIL restart_first got rem=%0d req 15", remaining);
    end
    for (int i = 0; i < 5; i++) begin
      idle(2);
      pulse_tick();
    end
    checks++;
    if (remaining !== 4'd10) begin
      errors++;
      $display("[TB] FAIL restart_mid got rem=%0d req 10", remaining);
    end
    base = exp_seen;
    do_start(2'd0);
    checks++;
    if ({expired, busy, remaining} !== {1'b0, 1'b1, 4'd6}) begin
      errors++;
      $display("[TB] FAIL restart_reload got exp=%b busy=%b rem=%0d req 0/1/6", expired, busy, remaining);
    end
    for (int i = 0; i < 5; i++) begin
      idle(2);
      pulse_tick();
    end
    checks++;
    if ({expired, busy, remaining} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL restart_five got exp=%b busy=%b rem=%0d req 0/1/1", expired, busy, remaining);
    end
    idle(2);
    pulse_tick();
    checks++;
    if ({expired, busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL restart_expire got exp=%b busy=%b req 1/0", expired, busy);
    end
    for (int i = 0; i < 10; i++) begin
      idle(2);
      pulse_tick();
    end
    checks++;
    if (exp_seen - base !== 1) begin
      errors++;
      $display("[TB] FAIL restart_single_expire got %0d pulses req 1", exp_seen - base);
    end
  endtask

  task test_coincident();
    interval      = 2'd1;
    start_timer   = 1'b1;
    one_hz_enable = 1'b1;
    step();
    start_timer   = 1'b0;
    one_hz_enable = 1'b0;
    checks++;
    if (remaining !== 4'd8) begin
      errors++;
      $display("[TB] FAIL start_tick_idle got rem=%0d req 8", remaining);
    end
    pulse_tick();
    checks++;
    if (remaining !== 4'd7) begin
      errors++;
      $display("[TB] FAIL start_tick_next got rem=%0d req 7", remaining);
    end
    time_param_sel = 2'd1;
    time_value     = 4'd5;
    prog_sync      = 1'b1;
    interval       = 2'd1;
    start_timer    = 1'b1;
    step();
    prog_sync      = 1'b0;
    start_timer    = 1'b0;
    checks++;
    if (remaining !== 4'd8) begin
      errors++;
      $display("[TB] FAIL start_prog_old got rem=%0d req 8", remaining);
    end
    do_start(2'd1);
    checks++;
    if (remaining !== 4'd5) begin
      errors++;
      $display("[TB] FAIL start_prog_new got rem=%0d req 5", remaining);
    end
    interval      = 2'd1;
    start_timer   = 1'b1;
    one_hz_enable = 1'b1;
    step();
    start_timer   = 1'b0;
    one_hz_enable = 1'b0;
    checks++;
    if ({busy, remaining} !== {1'b1, 4'd5}) begin
      errors++;
      $display("[TB] FAIL start_tick_run got busy=%b rem=%0d req 1/5", busy, remaining);
    end
    do_prog(2'd1, 4'd2);
    pulse_tick();
    checks++;
    if (remaining !== 4'd4) begin
      errors++;
      $display("[TB] FAIL write_during_run got rem=%0d req 4", remaining);
    end
  endtask

  task test_reset_mid();
    int base;
    logic [3:0] defaults [4];
    defaults[0] = 4'd6;
    defaults[1] = 4'd8;
    defaults[2] = 4'd15;
    defaults[3] = 4'd10;
    base = exp_seen;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({expired, busy, remaining} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got exp=%b busy=%b rem=%0d req 0/0/0", expired, busy, remaining);
    end
    pulse_tick();
    idle(2);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(2);
      pulse_tick();
    end
    checks++;
    if ({busy, remaining} !== 5'b0 || exp_seen != base) begin
      errors++;
      $display("[TB] FAIL reset_mid_no_expire got busy=%b rem=%0d pulses=%0d req 0/0/0", busy, remaining, exp_seen - base);
    end
    for (int e = 0; e < 4; e++) begin
      do_start(2'(e));
      checks++;
      if (remaining !== defaults[e]) begin
        errors++;
        $display("[TB] FAIL reset_table entry %0d got %0d req %0d", e, remaining, defaults[e]);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    one_hz_enable  = 1'b0;
    prog_sync      = 1'b0;
    time_param_sel = 2'd0;
    time_value     = 4'd0;
    interval       = 2'd0;
    start_timer    = 1'b0;
    test_reset();
    test_defaults();
    test_program();
    test_restart();
    test_coincident();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
